// File: rtl/serial_divider_if.sv
// Start/done handshake bundle between a divider and its requester.
// No flow control beyond start/busy: requests during busy are dropped by the slave.
interface serial_divider_if #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/serial_divider.sv
// Restoring divider, one quotient bit per clock MSB first; latency DIVIDEND_W+1 (1 on divide-by-zero).
// No queueing: start is only taken in IDLE/DONE, and requests while busy are ignored.
module serial_divider #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_divider_if.slave bus
);
  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic [DIVIDEND_W-1:0] work;
  logic [DIVISOR_W-1:0]  dvsr;
  logic [DIVISOR_W:0]    pr;
  logic [CNT_W-1:0]      cnt;

  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  remainder_q;
  logic                  div_by_zero_q;

  logic                  accept;
  logic                  busy_c;
  logic                  done_c;
  logic [DIVISOR_W:0]    pr_shift;
  logic [DIVISOR_W:0]    pr_nxt;
  logic [DIVIDEND_W-1:0] work_nxt;
  logic                  take;

  // One extra partial-remainder bit keeps the compare exact at divisor = all ones.
  always_comb begin
    pr_shift = {pr[DIVISOR_W-1:0], work[DIVIDEND_W-1]};
    take     = (pr_shift >= {1'b0, dvsr});
    pr_nxt   = take ? (pr_shift - {1'b0, dvsr}) : pr_shift;
    work_nxt = {work[DIVIDEND_W-2:0], take};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        done_c = (state == ST_DONE);
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = (bus.divisor == '0) ? ST_DONE : ST_CALC;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CALC: begin
        busy_c = 1'b1;
        if (cnt == '0) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work          <= '0;
      dvsr          <= '0;
      pr            <= '0;
      cnt           <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else if (accept) begin
      if (bus.divisor == '0) begin
        quotient_q    <= '1;
        remainder_q   <= bus.dividend[DIVISOR_W-1:0];
        div_by_zero_q <= 1'b1;
      end else begin
        work <= bus.dividend;
        dvsr <= bus.divisor;
        pr   <= '0;
        cnt  <= CNT_LOAD;
      end
    end else if (state == ST_CALC) begin
      work <= work_nxt;
      pr   <= pr_nxt;
      cnt  <= cnt - 1'b1;
      // Results are published only on the edge that enters DONE.
      if (cnt == '0) begin
        quotient_q    <= work_nxt;
        remainder_q   <= pr_nxt[DIVISOR_W-1:0];
        div_by_zero_q <= 1'b0;
      end
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;
endmodule
